// File: rtl/pipe_pkg.sv
// Shared decode/execute pipeline definitions: default field widths, kill-bit index,
// bubble constants and the per-edge load classification used by stage registers.
package pipe_pkg;

    localparam int unsigned ALU_OP_W_DEF = 4;
    localparam int unsigned CTRL_W_DEF   = 8;
    localparam int unsigned KILL_BIT_DEF = 7;

    localparam logic [ALU_OP_W_DEF-1:0] BUBBLE_ALU_OP = '0;
    localparam logic [CTRL_W_DEF-1:0]   BUBBLE_CTRL   = '0;

    // What the stage register does on a given edge.
    typedef enum logic [1:0] {
        LdHold,        // freeze: keep everything
        LdBubbleCnt,   // bubble caused by stall/flush/flush window (counted)
        LdBubble,      // bubble from empty or self-killed decode (not counted)
        LdPass         // real instruction moves into EX
    } load_e;

    // Width of a down-counter that must hold values 0..max_val, never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/decode_ex_bubble_reg_if.sv
// Decode-to-execute control bus: hazard controls and decoded fields in, registered
// EX-side controls and status out.
interface decode_ex_bubble_reg_if #(
    parameter int unsigned ALU_OP_W = 4,
    parameter int unsigned CTRL_W   = 8,
    parameter int unsigned CNT_W    = 16
);

    logic                freeze;
    logic                stall;
    logic                flush;
    logic                valid_in;
    logic [ALU_OP_W-1:0] alu_op;
    logic [CTRL_W-1:0]   ctrl;

    logic [ALU_OP_W-1:0] o_alu_op;
    logic [CTRL_W-1:0]   o_ctrl;
    logic                o_valid;
    logic                o_flush_busy;
    logic [CNT_W-1:0]    o_bubble_cnt;

    // Decode/hazard side.
    modport master (
        output freeze, stall, flush, valid_in, alu_op, ctrl,
        input  o_alu_op, o_ctrl, o_valid, o_flush_busy, o_bubble_cnt
    );

    // Pipeline register side.
    modport slave (
        input  freeze, stall, flush, valid_in, alu_op, ctrl,
        output o_alu_op, o_ctrl, o_valid, o_flush_busy, o_bubble_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset; sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/decode_ex_bubble_reg.sv
// Decode-to-execute control register with bubble insertion for stalls, killed or empty
// decode slots and multi-cycle flush windows, plus a global freeze and bubble counter.
module decode_ex_bubble_reg
    import pipe_pkg::*;
#(
    parameter int unsigned ALU_OP_W     = ALU_OP_W_DEF,
    parameter int unsigned CTRL_W       = CTRL_W_DEF,
    parameter int unsigned KILL_BIT     = KILL_BIT_DEF,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input logic                   clk,
    input logic                   rst,
    decode_ex_bubble_reg_if.slave bus
);

    localparam int unsigned REM_W = cnt_width(FLUSH_CYCLES);
    localparam logic [REM_W-1:0] REM_RELOAD = REM_W'(FLUSH_CYCLES - 1);

    load_e               w_load;
    logic [REM_W-1:0]    w_rem_d;
    logic                w_cnt_en;
    logic [CNT_W-1:0]    w_bubble_cnt;

    logic [ALU_OP_W-1:0] r_alu_op;
    logic [CTRL_W-1:0]   r_ctrl;
    logic                r_valid;
    logic [REM_W-1:0]    r_rem;
    logic                r_flush_busy;

    always_comb begin
        w_load  = LdPass;
        w_rem_d = r_rem;
        if (bus.freeze) begin
            w_load = LdHold;
        end else if (bus.flush) begin
            // A flush inside an open window restarts it.
            w_load  = LdBubbleCnt;
            w_rem_d = REM_RELOAD;
        end else if (r_rem != '0) begin
            w_load  = LdBubbleCnt;
            w_rem_d = r_rem - 1'b1;
        end else if (bus.stall) begin
            w_load = LdBubbleCnt;
        end else if (bus.ctrl[KILL_BIT] || !bus.valid_in) begin
            w_load = LdBubble;
        end
    end

    assign w_cnt_en = (w_load == LdBubbleCnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_op     <= ALU_OP_W'(BUBBLE_ALU_OP);
            r_ctrl       <= CTRL_W'(BUBBLE_CTRL);
            r_valid      <= 1'b0;
            r_rem        <= '0;
            r_flush_busy <= 1'b0;
        end else begin
            unique case (w_load)
                LdHold: begin
                end
                LdPass: begin
                    r_alu_op <= bus.alu_op;
                    r_ctrl   <= bus.ctrl;
                    r_valid  <= 1'b1;
                end
                default: begin
                    r_alu_op <= ALU_OP_W'(BUBBLE_ALU_OP);
                    r_ctrl   <= CTRL_W'(BUBBLE_CTRL);
                    r_valid  <= 1'b0;
                end
            endcase
            if (w_load != LdHold) begin
                r_rem        <= w_rem_d;
                r_flush_busy <= (w_rem_d != '0);
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_bubble_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_cnt_en),
        .o_count (w_bubble_cnt)
    );

    assign bus.o_alu_op     = r_alu_op;
    assign bus.o_ctrl       = r_ctrl;
    assign bus.o_valid      = r_valid;
    assign bus.o_flush_busy = r_flush_busy;
    assign bus.o_bubble_cnt = w_bubble_cnt;

endmodule

// File: doc/decode_ex_bubble_reg.md
Name: decode_ex_bubble_reg

Overview:
- Parametrised decode-to-execute control pipeline register with hazard bubble insertion. Successor to the combinational decode control mux.
- Adds four things: registered outputs, a global freeze (hold), multi-cycle flush squashing, and a saturating bubble performance counter.
- Sits between the control unit/ALU decoder and the EX stage. All control bits reaching EX pass through it.

Parameters:
- ALU_OP_W, 4, width of ALU opcode field
- CTRL_W, 8, width of control-unit signal bundle
- KILL_BIT, 7, index in ctrl of the decoder's self-kill bit (illegal/nop marker); must be < CTRL_W
- FLUSH_CYCLES, 2, consecutive register loads squashed per flush; must be >= 1
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- freeze  in  1  global pipeline hold (e.g. memory wait); register and counters hold
- stall  in  1  load-use hazard; inject one bubble into EX this edge
- flush  in  1  branch/jump redirect; squash this and the following FLUSH_CYCLES-1 loads
- valid_in  in  1  decode holds a real instruction
- alu_op  in  ALU_OP_W  decoded ALU operation
- ctrl  in  CTRL_W  decoded control bundle
- o_alu_op  out  ALU_OP_W  registered ALU op to EX
- o_ctrl  out  CTRL_W  registered control bundle to EX
- o_valid  out  1  EX holds a real instruction
- o_flush_busy  out  1  squash window still open (remaining count != 0)
- o_bubble_cnt  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. Takes priority over everything. Resets o_alu_op=0, o_ctrl=0, o_valid=0, remaining flush count=0, o_bubble_cnt=0. Because remaining count is 0, o_flush_busy=0. Asserting rst mid-flush cancels the flush window.
- Latency: one cycle, inputs to outputs. All outputs are registered; no combinational input-to-output path.
- Per-edge priority when not in reset:
  1. freeze=1: hold all state, including the remaining count and o_bubble_cnt. stall and flush are ignored that edge. The redirect source must hold flush until freeze drops.
  2. flush=1: load bubble; set remaining = FLUSH_CYCLES-1. A flush during an active window restarts it.
  3. remaining != 0: load bubble; remaining decrements by 1.
  4. stall=1, ctrl[KILL_BIT]=1, or valid_in=0: load bubble.
  5. Otherwise: load alu_op, ctrl; o_valid=1.
- Bubble definition: o_alu_op=0, o_ctrl=0, o_valid=0. A bubble always clears the full ctrl bundle, kill bit included.
- Bubble counter:
  - Increments by 1 on every edge where cases 2, 3 or 4 load a bubble caused by stall, flush or flush window.
  - valid_in=0 alone does not count.
  - ctrl[KILL_BIT]=1 alone does not count.
  - Saturates at all-ones; no wrap.
- o_flush_busy: equals (remaining != 0), registered.
- With FLUSH_CYCLES=1: remaining is never nonzero and o_flush_busy stays 0.
- Simultaneous stall and flush: treated as flush; counter increments once.
- Remaining-count width: $clog2(FLUSH_CYCLES+1), minimum 1.

Decomposition:
- Shared pipeline package (pipe_pkg) holds:
  - default widths ALU_OP_W/CTRL_W
  - KILL_BIT index constant
  - BUBBLE_ALU_OP and BUBBLE_CTRL zero constants, shared with other stage registers
- One natural sub-module: sat_counter (parametrised width, enable, sync reset, saturating). Used for o_bubble_cnt and reusable for other perf counters.
- Flush-window counter stays inline.

Test Plan:
- Reset and pass-through: rst=1 for 2 cycles, then valid_in=1, alu_op=4'h3, ctrl=8'h15 -> outputs 0/0/0 during reset; o_alu_op=3, o_ctrl=15, o_valid=1 one cycle after.
- Stall: stall=1 for one cycle with ctrl=8'h22 -> next cycle o_ctrl=0, o_valid=0, o_bubble_cnt 0->1; following cycle o_ctrl=22.
- Flush window, FLUSH_CYCLES=2:
  - flush pulse one cycle -> 2 consecutive bubbles, o_flush_busy=1 for exactly 1 cycle, counter +2.
  - Re-flush on the 2nd cycle -> window restarts, 3 bubbles total.
- Freeze mid-flush: flush, then freeze=1 for 3 cycles -> outputs, remaining count and counter frozen; remaining bubble issued after freeze drops. Also check stall during freeze is ignored.
- Kill bit and saturation:
  - ctrl=8'h80, stall=0 -> bubble, counter unchanged.
  - CNT_W=2, 5 stalls -> counter reads 3 and holds.
- Reset mid-flush: flush then rst next cycle -> o_flush_busy=0; first post-reset valid instruction passes immediately.
